rv_mem_arbiter: RTL and testbench

Sequential arbiter that shares one unified memory port between the core's instruction-fetch stage and data-memory stage. It grants one transaction at a time, sequences it through request, grant and response on the memory side, and returns the response to the winning requester. It also generates per-stage stall signals so the pipeline holds while its access is outstanding. It sits between the core pipeline and the single external memory.

---
 rtl/rv_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_rv_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one memory port between instruction fetch and data access,
// one transaction at a time. Defining RV_ARB_STARVE_GUARD_EN adds a fetch starvation guard.
module rv_mem_arbiter #(
  parameter int AW         = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  input  logic          if_kill_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [31:0]   if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [63:0]   d_wdata_i,
  input  logic [7:0]    d_be_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [63:0]   d_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [63:0]   mem_wdata_o,
  output logic [7:0]    mem_be_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [63:0]   mem_rdata_i,
  output logic          stall_if_o,
  output logic          stall_mem_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_e;

  state_e        state_q, state_d;
  logic          grant_if, grant_d, fetch_first, resp_done;
  logic          owner_d_q, addr2_q, kill_q, kill_d;
  logic          mem_req_q, mem_req_d, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [63:0]   mem_wdata_q;
  logic [7:0]    mem_be_q;

`ifdef RV_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_q, starve_d;

  assign fetch_first = (starve_q >= CW'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (grant_if)
      starve_d = '0;
    else if (grant_d && if_req_i && !fetch_first)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX != 0);
  assign fetch_first       = 1'b0;
`endif

  // Data normally wins because it belongs to the older instruction.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (rstn && state_q == S_IDLE) begin
      if (if_req_i && (!d_req_i || fetch_first)) grant_if = 1'b1;
      else if (d_req_i)                          grant_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_if || grant_d) state_d = S_REQ;
      S_REQ:   if (mem_gnt_i)           state_d = S_RESP;
      S_RESP:  if (mem_rvalid_i)        state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    resp_done   = rstn && (state_q == S_RESP) && mem_rvalid_i;
    if_gnt_o    = grant_if;
    d_gnt_o     = grant_d;
    if_rvalid_o = resp_done && !owner_d_q && !kill_q && !if_kill_i;
    d_rvalid_o  = resp_done && owner_d_q;
    if_rdata_o  = '0;
    d_rdata_o   = '0;
    if (if_rvalid_o) if_rdata_o = addr2_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
    if (d_rvalid_o)  d_rdata_o  = mem_rdata_i;
    stall_if_o  = rstn && if_req_i && !if_rvalid_o;
    stall_mem_o = rstn && d_req_i && !d_rvalid_o;
  end

  always_comb begin
    mem_req_d = mem_req_q;
    if (grant_if || grant_d)               mem_req_d = 1'b1;
    else if (state_q == S_REQ && mem_gnt_i) mem_req_d = 1'b0;
    kill_d = kill_q;
    if (state_q == S_IDLE || resp_done)     kill_d = 1'b0;
    else if (!owner_d_q && if_kill_i)       kill_d = 1'b1;
  end

  // Request fields are captured once at grant and held through all wait states.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      owner_d_q   <= 1'b0;
      addr2_q     <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      mem_req_q <= mem_req_d;
      kill_q    <= kill_d;
      if (grant_d) begin
        mem_we_q    <= d_we_i;
        mem_addr_q  <= d_addr_i;
        mem_wdata_q <= d_wdata_i;
        mem_be_q    <= d_be_i;
        owner_d_q   <= 1'b1;
      end else if (grant_if) begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= if_addr_i;
        mem_wdata_q <= '0;
        mem_be_q    <= '0;
        owner_d_q   <= 1'b0;
        addr2_q     <= if_addr_i[2];
      end
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Testbench for rv_mem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rv_mem_arbiter;
  localparam int AW   = 64;
  localparam int SMAX = 4;
`ifdef RV_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
  localparam int EXP_FIRST_IF = 4;
`else
  localparam bit GUARD = 1'b0;
  localparam int EXP_FIRST_IF = -1;
`endif

  logic clk, rstn;
  logic if_req_i, if_kill_i, if_gnt_o, if_rvalid_o;
  logic [AW-1:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
  logic [AW-1:0] d_addr_i;
  logic [63:0] d_wdata_i, d_rdata_o;
  logic [7:0] d_be_i;
  logic mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [AW-1:0] mem_addr_o;
  logic [63:0] mem_wdata_o, mem_rdata_i;
  logic [7:0] mem_be_o;
  logic stall_if_o, stall_mem_o;

  int checks = 0;
  int errors = 0;
  int gnt_waits = 0;
  int rv_waits = 0;
  logic force_rv, resp_rv;

  assign mem_rvalid_i = resp_rv | force_rv;

  rv_mem_arbiter #(.AW(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rstn(rstn),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: configurable grant and response wait states.
  initial begin : responder
    int gcnt, rcnt;
    logic outst, prev_req, prev_gnt, prev_rv;
    gcnt = 0; rcnt = 0; outst = 0; prev_req = 0; prev_gnt = 0; prev_rv = 0;
    mem_gnt_i = 1'b0;
    resp_rv   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rstn) begin
        outst = 0; prev_req = 0; prev_gnt = 0; prev_rv = 0;
        mem_gnt_i = 1'b0;
        resp_rv   = 1'b0;
      end else begin
        if (prev_req && prev_gnt) begin
          outst = 1;
          rcnt  = rv_waits;
        end else if (prev_rv) begin
          outst = 0;
        end
        mem_gnt_i = 1'b0;
        if (mem_req_o) begin
          if (!prev_req) gcnt = gnt_waits;
          mem_gnt_i = (gcnt == 0);
          if (gcnt > 0) gcnt--;
        end
        resp_rv = 1'b0;
        if (outst) begin
          resp_rv = (rcnt == 0);
          if (rcnt > 0) rcnt--;
        end
        prev_req = mem_req_o;
        prev_gnt = mem_gnt_i;
        prev_rv  = resp_rv;
      end
    end
  end

  // Reference model: one outstanding transaction record, checked every cycle.
  logic        m_busy, m_acc, m_owner_d, m_kill, m_we, m_addr2;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_be;
  int          m_starve;

  initial begin
    m_busy = 0; m_acc = 0; m_owner_d = 0; m_kill = 0; m_we = 0; m_addr2 = 0;
    m_addr = '0; m_wdata = '0; m_be = '0; m_starve = 0;
  end

  always @(negedge clk) begin : compare
    logic fw, eg_if, eg_d, done, e_ifrv, e_drv;
    logic [31:0] e_ifd;
    if (!rstn) begin
      chk("rst_if_gnt", if_gnt_o, 0);       chk("rst_d_gnt", d_gnt_o, 0);
      chk("rst_if_rvalid", if_rvalid_o, 0); chk("rst_d_rvalid", d_rvalid_o, 0);
      chk("rst_if_rdata", if_rdata_o, 0);   chk("rst_d_rdata", d_rdata_o, 0);
      chk("rst_mem_req", mem_req_o, 0);     chk("rst_mem_we", mem_we_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);   chk("rst_mem_wdata", mem_wdata_o, 0);
      chk("rst_mem_be", mem_be_o, 0);
      chk("rst_stall_if", stall_if_o, 0);   chk("rst_stall_mem", stall_mem_o, 0);
      m_busy = 0; m_acc = 0; m_kill = 0; m_starve = 0;
      m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
    end else begin
      fw     = if_req_i && (!d_req_i || (GUARD && m_starve >= SMAX));
      eg_if  = !m_busy && fw;
      eg_d   = !m_busy && d_req_i && !fw;
      done   = m_busy && m_acc && mem_rvalid_i;
      e_ifrv = done && !m_owner_d && !m_kill && !if_kill_i;
      e_drv  = done && m_owner_d;
      e_ifd  = e_ifrv ? (m_addr2 ? mem_rdata_i[63:32] : mem_rdata_i[31:0]) : 32'h0;
      chk("if_gnt", if_gnt_o, eg_if);
      chk("d_gnt", d_gnt_o, eg_d);
      chk("if_rvalid", if_rvalid_o, e_ifrv);
      chk("d_rvalid", d_rvalid_o, e_drv);
      chk("if_rdata", if_rdata_o, e_ifd);
      chk("d_rdata", d_rdata_o, e_drv ? mem_rdata_i : 64'h0);
      chk("stall_if", stall_if_o, if_req_i && !e_ifrv);
      chk("stall_mem", stall_mem_o, d_req_i && !e_drv);
      chk("mem_req", mem_req_o, m_busy && !m_acc);
      if (m_busy && !m_acc) begin
        chk("mem_addr", mem_addr_o, m_addr);
        chk("mem_we", mem_we_o, m_we);
        if (m_owner_d) begin
          chk("mem_wdata", mem_wdata_o, m_wdata);
          chk("mem_be", mem_be_o, m_be);
        end
      end
      if (m_busy && !m_owner_d && if_kill_i) m_kill = 1;
      if (done) begin
        m_busy = 0;
        m_kill = 0;
      end else if (m_busy && !m_acc && mem_gnt_i) begin
        m_acc = 1;
      end
      if (eg_if) begin
        m_busy = 1; m_acc = 0; m_owner_d = 0; m_kill = 0;
        m_addr = if_addr_i; m_addr2 = if_addr_i[2]; m_we = 0;
        m_starve = 0;
      end
      if (eg_d) begin
        m_busy = 1; m_acc = 0; m_owner_d = 1; m_kill = 0;
        m_addr = d_addr_i; m_we = d_we_i; m_wdata = d_wdata_i; m_be = d_be_i;
        if (if_req_i && m_starve < SMAX) m_starve++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int n, at, nreq, ndg, first_if;
    logic seen;
    rstn = 1'b0; force_rv = 1'b0;
    if_req_i = 0; if_addr_i = '0; if_kill_i = 0;
    d_req_i = 1; d_we_i = 0; d_addr_i = 64'h40; d_wdata_i = '0; d_be_i = '0;
    mem_rdata_i = 64'h5555_6666_7777_8888;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_d_gnt", d_gnt_o, 0);
    chk("init_stall_mem", stall_mem_o, 0);
    chk("init_mem_req", mem_req_o, 0);
    step(); rstn = 1'b1; d_req_i = 0;
    step();

    // single fetch, zero-wait memory
    if_req_i = 1; if_addr_i = 64'h1004; mem_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk); chk("sf_gnt_c0", if_gnt_o, 1);
    @(negedge clk); chk("sf_mreq_c1", mem_req_o, 1); chk("sf_maddr", mem_addr_o, 64'h1004);
    @(negedge clk); chk("sf_rvalid_c2", if_rvalid_o, 1); chk("sf_rdata", if_rdata_o, 32'hAAAA_BBBB);
    step(); if_req_i = 0;
    step();

    // simultaneous fetch and load
    if_req_i = 1; if_addr_i = 64'h1000; d_req_i = 1; d_we_i = 0; d_addr_i = 64'h80;
    mem_rdata_i = 64'h0123_4567_89AB_CDEF;
    @(negedge clk); chk("sim_dgnt_c0", d_gnt_o, 1); chk("sim_ifgnt_c0", if_gnt_o, 0);
    chk("sim_stall_if_c0", stall_if_o, 1);
    @(negedge clk); chk("sim_stall_if_c1", stall_if_o, 1);
    @(negedge clk); chk("sim_drv_c2", d_rvalid_o, 1); chk("sim_drdata", d_rdata_o, 64'h0123_4567_89AB_CDEF);
    chk("sim_ifrv_c2", if_rvalid_o, 0); chk("sim_stall_if_c2", stall_if_o, 1);
    step(); d_req_i = 0;
    @(negedge clk); chk("sim_ifgnt_c3", if_gnt_o, 1); chk("sim_stall_if_c3", stall_if_o, 1);
    @(negedge clk); chk("sim_stall_if_c4", stall_if_o, 1);
    @(negedge clk); chk("sim_ifrv_c5", if_rvalid_o, 1); chk("sim_ifrdata", if_rdata_o, 32'h89AB_CDEF);
    chk("sim_stall_if_c5", stall_if_o, 0);
    step(); if_req_i = 0;
    step();

    // store with 2 grant waits and 3 response waits
    gnt_waits = 2; rv_waits = 3;
    d_req_i = 1; d_we_i = 1; d_addr_i = 64'h2000; d_wdata_i = 64'hDEAD_BEEF_0BAD_F00D; d_be_i = 8'h0F;
    n = 0; at = -1; nreq = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mem_req_o) begin
        nreq++;
        chk("st_mem_be", mem_be_o, 8'h0F);
        chk("st_mem_we", mem_we_o, 1);
      end
      if (d_rvalid_o) begin n++; at = k; end
      step();
      if (n > 0) d_req_i = 0;
    end
    chk("st_rvalid_count", n, 1);
    chk("st_rvalid_cycle", at, 7);
    chk("st_req_cycles", nreq, 3);
    gnt_waits = 0; rv_waits = 0; d_we_i = 0; d_be_i = '0;

    // fetch killed during RESP
    rv_waits = 2; if_req_i = 1; if_addr_i = 64'h1400; mem_rdata_i = 64'h9999_8888_7777_6666;
    @(negedge clk); chk("kill_gnt", if_gnt_o, 1);
    @(negedge clk);
    step(); if_kill_i = 1; if_req_i = 0;
    @(negedge clk);
    step(); if_kill_i = 0;
    n = 0; seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (if_rvalid_o) n++;
      if (mem_rvalid_i) seen = 1;
    end
    chk("kill_mem_rvalid_seen", seen, 1);
    chk("kill_no_if_rvalid", n, 0);
    step(); rv_waits = 0;
    if_req_i = 1; if_addr_i = 64'h3000; mem_rdata_i = 64'h1111_2222_3333_4444;
    @(negedge clk); chk("kill_new_gnt", if_gnt_o, 1);
    @(negedge clk); chk("kill_new_maddr", mem_addr_o, 64'h3000);
    @(negedge clk); chk("kill_new_rvalid", if_rvalid_o, 1); chk("kill_new_rdata", if_rdata_o, 32'h3333_4444);
    step(); if_req_i = 0;
    step();

    // continuous contention for starvation behaviour
    d_req_i = 1; d_we_i = 0; d_addr_i = 64'h100; if_req_i = 1; if_addr_i = 64'h4000;
    ndg = 0; first_if = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if_gnt_o && first_if < 0) first_if = ndg;
      if (d_gnt_o) ndg++;
    end
    chk("starve_first_if_gnt", first_if, EXP_FIRST_IF);
    step(); rstn = 0; d_req_i = 0; if_req_i = 0;
    step(); rstn = 1;
    step();

    // reset during RESP, stale response afterwards
    rv_waits = 4; if_req_i = 1; if_addr_i = 64'h5008;
    @(negedge clk); chk("rst_op_gnt", if_gnt_o, 1);
    @(negedge clk);
    @(negedge clk);
    step(); rstn = 0; if_req_i = 0;
    @(negedge clk); chk("rst_op_mem_req", mem_req_o, 0); chk("rst_op_maddr", mem_addr_o, 0);
    step(); rstn = 1; rv_waits = 0;
    step(); force_rv = 1;
    @(negedge clk); chk("stale_if_rv", if_rvalid_o, 0); chk("stale_d_rv", d_rvalid_o, 0);
    step(); force_rv = 0;
    d_req_i = 1; d_we_i = 0; d_addr_i = 64'h6000; mem_rdata_i = 64'hCAFE_F00D_1234_5678;
    @(negedge clk); chk("post_rst_dgnt", d_gnt_o, 1);
    @(negedge clk); chk("post_rst_mreq", mem_req_o, 1); chk("post_rst_maddr", mem_addr_o, 64'h6000);
    @(negedge clk); chk("post_rst_drv", d_rvalid_o, 1); chk("post_rst_drdata", d_rdata_o, 64'hCAFE_F00D_1234_5678);
    step(); d_req_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
